// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, imem request issue and 32-bit extraction to decode; FETCH_WORD_REUSE_EN adds a one-word buffer.
// Latency: imem_valid at +1, inst_valid at +2; outputs hold while inst_ready is low, imem_req stays high until the response.
module instr_fetch_unit #(
  parameter int          XLEN     = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_valid,
  input  logic            imem_err,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [31:0]     inst_pc,
  output logic            inst_fault,
  output logic            fault_misaligned
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DELIVER = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] fetched_inst;
  logic        redirect_misaligned;
  logic        resp_take;

`ifdef FETCH_WORD_REUSE_EN
  logic [63:0] buf_word;
  logic [28:0] buf_tag;
  logic        buf_vld;
  logic        reuse_hit;
`endif

  // The request is dropped in the response cycle so the controller never sees a second request for the same word.
  assign imem_req   = (state == S_FETCH) && !imem_valid;
  assign imem_addr  = pc;
  assign inst_valid = (state == S_DELIVER);

  assign fetched_inst        = pc[2] ? imem_data[63:32] : imem_data[31:0];
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign resp_take           = imem_valid && !kill;

`ifdef FETCH_WORD_REUSE_EN
  // Only a lower-half instruction can be followed by its upper half from the same word.
  assign reuse_hit = buf_vld && !pc[2] && (buf_tag == pc[31:3]);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= S_FETCH;
      pc               <= RESET_PC;
      kill             <= 1'b0;
      inst             <= 32'h0;
      inst_pc          <= 32'h0;
      inst_fault       <= 1'b0;
      fault_misaligned <= 1'b0;
`ifdef FETCH_WORD_REUSE_EN
      buf_word         <= 64'h0;
      buf_tag          <= 29'h0;
      buf_vld          <= 1'b0;
`endif
    end else begin
      kill <= 1'b0;
      if (redirect_valid) begin
        // A request outstanding at redirect time returns next cycle and must be ignored.
        pc   <= redirect_pc;
        kill <= imem_req;
`ifdef FETCH_WORD_REUSE_EN
        buf_vld <= 1'b0;
`endif
        if (redirect_misaligned) begin
          state            <= S_DELIVER;
          inst             <= 32'h0;
          inst_pc          <= redirect_pc;
          inst_fault       <= 1'b1;
          fault_misaligned <= 1'b1;
        end else begin
          state <= S_FETCH;
        end
      end else begin
        case (state)
          S_FETCH: begin
            if (resp_take) begin
              state            <= S_DELIVER;
              inst             <= imem_err ? 32'h0 : fetched_inst;
              inst_pc          <= pc;
              inst_fault       <= imem_err;
              fault_misaligned <= 1'b0;
`ifdef FETCH_WORD_REUSE_EN
              buf_word <= imem_data[63:0];
              buf_tag  <= pc[31:3];
              buf_vld  <= !imem_err;
`endif
            end
          end
          S_DELIVER: begin
            if (inst_ready) begin
              if (inst_fault) begin
                state <= S_HALT;
              end else begin
                pc <= pc + 32'd4;
`ifdef FETCH_WORD_REUSE_EN
                if (reuse_hit) begin
                  state   <= S_DELIVER;
                  inst    <= buf_word[63:32];
                  inst_pc <= pc + 32'd4;
                end else begin
                  state <= S_FETCH;
                end
`else
                state <= S_FETCH;
`endif
              end
            end
          end
          S_HALT: begin
            state <= S_HALT;
          end
          default: begin
            state <= S_FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a stream-level fetch model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic        imem_err;
  logic [63:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        fault_misaligned;

  logic        data_busy;
  logic        err_en;
  logic [28:0] err_tag;
  logic        m_valid;
  logic [31:0] m_addr;
  logic        saw_bad_req;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_WORD_REUSE_EN
  localparam int SECOND_CYC = 3;
`else
  localparam int SECOND_CYC = 5;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_err(imem_err), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .fault_misaligned(fault_misaligned)
  );

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h7F4A_7C15;
  endfunction

  function automatic logic [63:0] word_at(input logic [28:0] tag);
    logic [31:0] a;
    a = {tag, 3'b000};
    if (tag == 29'h0) return 64'h00500093_00100013;
    return {hsh(a + 32'd4), hsh(a)};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [63:0] w;
    w = word_at(pc[31:3]);
    return pc[2] ? w[63:32] : w[31:0];
  endfunction

  // Memory controller: accepts a request when idle (no data access, no response in flight), answers next cycle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_addr  <= 32'h0;
    end else begin
      m_valid <= imem_req && !data_busy && !m_valid;
      if (imem_req && !data_busy && !m_valid) m_addr <= imem_addr;
      if (imem_req && imem_addr[1:0] != 2'b00) saw_bad_req <= 1'b1;
    end
  end

  assign imem_valid = m_valid;
  assign imem_data  = word_at(m_addr[31:3]);
  assign imem_err   = m_valid && err_en && (m_addr[31:3] == err_tag);

  task automatic test_reset;
    resetn = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    data_busy = 1'b0; err_en = 1'b0; err_tag = 29'h0; saw_bad_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst got %h/%h want 0/0", inst, inst_pc); end
    checks++; if (inst_fault !== 1'b0 || fault_misaligned !== 1'b0) begin errors++; $display("FAIL reset_fault got %b%b want 00", inst_fault, fault_misaligned); end
  endtask

  task automatic test_reset_fetch;
    resetn = 1'b1;
    for (int c = 0; c <= SECOND_CYC; c++) begin
      if (c != 0) @(negedge clk);
      if (c == 0) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL fetch_c0_req got %b@%h want 1@0", imem_req, imem_addr); end
      end
      if (c == 1) begin
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_c1 got req=%b vld=%b want 0 0", imem_req, inst_valid); end
      end
      if (c == 2) begin
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h00100013 || inst_pc !== 32'h0) begin errors++; $display("FAIL fetch_c2 got %b %h@%h want 1 00100013@0", inst_valid, inst, inst_pc); end
      end
      if (c == SECOND_CYC) begin
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h00500093 || inst_pc !== 32'h4) begin errors++; $display("FAIL fetch_second got %b %h@%h want 1 00500093@4", inst_valid, inst, inst_pc); end
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h00500093 || inst_pc !== 32'h4 || imem_req !== 1'b0 || imem_addr !== 32'h4) begin
        errors++; $display("FAIL backpressure c%0d got vld=%b %h@%h req=%b pc=%h", c, inst_valid, inst, inst_pc, imem_req, imem_addr);
      end
    end
  endtask

  task automatic test_stale_response;
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stale_req got %b@%h want 1@8", imem_req, imem_addr); end
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 10 && !inst_valid; k++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== exp_inst(32'h100) || inst_fault !== 1'b0) begin
      errors++; $display("FAIL stale_deliver got %b %h@%h f=%b want 1 %h@100", inst_valid, inst, inst_pc, inst_fault, exp_inst(32'h100));
    end
  endtask

  task automatic test_misaligned;
    saw_bad_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || fault_misaligned !== 1'b1 || inst_pc !== 32'h102 || inst !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL misaligned got v=%b f=%b m=%b %h@%h req=%b", inst_valid, inst_fault, fault_misaligned, inst, inst_pc, imem_req);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_mis c%0d got vld=%b req=%b want 0 0", c, inst_valid, imem_req); end
    end
    checks++; if (saw_bad_req !== 1'b0) begin errors++; $display("FAIL mis_no_req got %b want 0", saw_bad_req); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 10 && !inst_valid; k++) @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== exp_inst(32'h200)) begin errors++; $display("FAIL halt_exit got %b %h@%h want 1 @200", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_access_error;
    err_en = 1'b1; err_tag = 29'h60;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 10 && !inst_valid; k++) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || fault_misaligned !== 1'b0 || inst_pc !== 32'h300 || inst !== 32'h0) begin
      errors++; $display("FAIL access_err got v=%b f=%b m=%b %h@%h want 1 1 0 0@300", inst_valid, inst_fault, fault_misaligned, inst, inst_pc);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_err c%0d got vld=%b req=%b want 0 0", c, inst_valid, imem_req); end
    end
    err_en = 1'b0;
  endtask

  task automatic test_data_contention;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0; data_busy = 1'b1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("FAIL cont_req got %b@%h want 1@400", imem_req, imem_addr); end
    @(negedge clk);
    data_busy = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL cont_hold got %b want 1", imem_req); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL cont_early got %b want 0", inst_valid); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h400 || inst !== exp_inst(32'h400)) begin errors++; $display("FAIL cont_deliver got %b %h@%h want 1 %h@400", inst_valid, inst, inst_pc, exp_inst(32'h400)); end
  endtask

  // Model: the delivered stream is pc, pc+4, ... from the last redirect, halting after a consumed fault.
  task automatic test_random;
    logic [31:0] exp_pc;
    logic        halted;
    logic        mis;
    logic        aerr;
    int          idle;
    int          delivered;
    exp_pc = 32'h400; halted = 1'b0; idle = 0; delivered = 0;
    err_en = 1'b1; err_tag = 29'h5;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      mis  = (exp_pc[1:0] != 2'b00);
      aerr = !mis && (exp_pc[31:3] == err_tag);
      if (inst_valid) begin
        checks++;
        if (halted || inst_pc !== exp_pc || inst_fault !== (mis || aerr) || fault_misaligned !== mis ||
            inst !== ((mis || aerr) ? 32'h0 : exp_inst(exp_pc))) begin
          errors++; $display("FAIL rand_inst cyc%0d got %h@%h f=%b m=%b want %h@%h f=%b m=%b halted=%b", cyc, inst, inst_pc,
                             inst_fault, fault_misaligned, exp_inst(exp_pc), exp_pc, mis || aerr, mis, halted);
        end
      end
      if (imem_req) begin
        checks++;
        if (halted || imem_addr !== exp_pc || imem_addr[1:0] != 2'b00) begin
          errors++; $display("FAIL rand_req cyc%0d got addr %h want %h halted=%b", cyc, imem_addr, exp_pc, halted);
        end
      end
      idle = (halted || inst_valid) ? 0 : idle + 1;
      if (idle > 40) begin
        checks++; errors++; idle = 0;
        $display("FAIL rand_stall cyc%0d no delivery for 40 cycles at pc %h", cyc, exp_pc);
      end
      inst_ready     = ($urandom_range(0, 3) != 0);
      data_busy      = ($urandom_range(0, 3) == 0);
      redirect_valid = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0:       redirect_pc = 32'hFFFF_FFF8;
        1:       redirect_pc = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
        default: redirect_pc = {$urandom_range(0, 63), 2'b00};
      endcase
      if (redirect_valid) begin
        exp_pc = redirect_pc; halted = 1'b0; idle = 0;
      end else if (inst_valid && inst_ready) begin
        delivered++;
        if (mis || aerr) halted = 1'b1;
        else exp_pc = exp_pc + 32'd4;
      end
    end
    redirect_valid = 1'b0; inst_ready = 1'b0; data_busy = 1'b0;
    checks++; if (delivered < 300) begin errors++; $display("FAIL rand_throughput got %0d want >= 300", delivered); end
  endtask

  task automatic test_reset_mid;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_fault !== 1'b0) begin
      errors++; $display("FAIL reset_mid got req=%b addr=%h vld=%b %h@%h f=%b", imem_req, imem_addr, inst_valid, inst, inst_pc, inst_fault);
    end
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_backpressure();
    test_stale_response();
    test_misaligned();
    test_access_error();
    test_data_contention();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Front-end stage that generates the program counter and issues instruction requests to the memory controller's instruction port.
- Extracts the 32-bit instruction from the returned 64-bit memory word and hands it to decode over a valid/ready handshake.
- Handles control-flow redirects, discards stale responses and reports fetch faults.
- Sits directly upstream of the memory controller's `imem_*` port and upstream of decode.

## Interface
Parameters:
- `XLEN`, default 64: memory data width; must be 64, since two instructions are packed per word.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports (reset `resetn`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `resetn`  in  1  async active-low reset
- `imem_req`  out  1  instruction request to memory controller
- `imem_addr`  out  32  byte address of request (= current PC)
- `imem_valid`  in  1  response valid (one cycle after acceptance)
- `imem_err`  in  1  response access error, qualified by `imem_valid`
- `imem_data`  in  XLEN  64-bit word containing the instruction
- `redirect_valid`  in  1  branch/jump/trap redirect
- `redirect_pc`  in  32  redirect target
- `inst_valid`  out  1  instruction available to decode
- `inst_ready`  in  1  decode accepts instruction
- `inst`  out  32  instruction (0 when faulted)
- `inst_pc`  out  32  PC of `inst`
- `inst_fault`  out  1  delivered entry is a fault
- `fault_misaligned`  out  1  fault cause: 1 = PC[1:0]≠0, 0 = access error

## Operation
- **States:**
  - FETCH: `imem_req` = ~`imem_valid`, `imem_addr` = pc.
  - DELIVER: `inst_valid` = 1, outputs come from holding registers.
  - HALT: no requests.
- **FETCH:**
  - `imem_req` is held high until `imem_valid`. Acceptance is not visible; the response is the only acknowledgement.
  - When `imem_valid` is high (and not being killed), latch the instruction and go to DELIVER:
    - `inst` = pc[2] ? `imem_data`[63:32] : `imem_data`[31:0].
    - `inst_pc` = pc.
    - `inst_fault` = `imem_err`, `fault_misaligned` = 0.
- **DELIVER:**
  - On `inst_valid & inst_ready`, a non-fault entry sets pc ← pc+4 (32-bit wrap) and returns to FETCH.
  - A consumed fault entry goes to HALT.
- **HALT:** the unit leaves HALT only on redirect.
- **Redirect (highest priority, any state):**
  - pc ← `redirect_pc`; the held instruction is dropped; next state is FETCH.
  - If `redirect_pc`[1:0]≠0: the next state is DELIVER with `inst`=0, `inst_pc`=`redirect_pc`, `inst_fault`=1, `fault_misaligned`=1. No memory request is made.
- **Kill flag:**
  - Set when a redirect occurs in a cycle with `imem_req`=1.
  - The next cycle, any `imem_valid` is discarded. The flag clears unconditionally after that one cycle.
  - A response arriving in the redirect cycle itself is discarded.
- **Simultaneous events:**
  - Redirect in the same cycle as `inst_ready` in DELIVER: the redirect wins and the consumed instruction's pc+4 is not applied.
- **Assumed memory-side behaviour:** the memory controller samples `imem_req` only when idle and may be busy with a data access. `imem_req` therefore stays high across data accesses.

## Timing
- **Reset values:**
  - State FETCH, pc=`RESET_PC`, kill=0.
  - `imem_req`=1, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_fault`=0, `fault_misaligned`=0.
  - The memory controller shares the reset, so no access occurs while `resetn` is low.
- **Latency:** FETCH entered at cycle N with the memory idle gives `imem_valid` at N+1 and `inst_valid` at N+2. With `inst_ready` high, FETCH resumes at N+3, so steady state is 1 instruction / 3 cycles.
- **Data-access interference:** each data access in progress delays the response by 1 cycle per access.
- **Reset mid-operation:** returns to reset values immediately (async). An in-flight response is lost, because the controller resets with the unit.
- **Handshake rule:** `inst`, `inst_pc`, `inst_fault`, `fault_misaligned` are stable while `inst_valid`=1 and `inst_ready`=0.

## Configuration
`FETCH_WORD_REUSE_EN`:
- **Defined:**
  - The latched 64-bit word and its tag pc[31:3] are kept in a buffer with a valid bit.
  - On consuming a non-fault lower-half instruction (pc[2]=0) with the buffer valid, the unit stays in DELIVER next cycle. The upper half is presented with `inst_pc`=pc+4 and no memory request.
  - Sequential throughput rises to 2 instructions / 4 cycles.
  - The buffer is invalidated on redirect, on `imem_err`, and on reset.
  - There is no coherence with stores.
- **Undefined:** every instruction issues its own request. No word buffer is synthesized.

## Test plan
- **Reset fetch:** `RESET_PC`=0, memory word 0 = 64'h00500093_00100013, `inst_ready`=1. Required: `imem_req` at cycle 0; `inst`=32'h00100013/`inst_pc`=0 at cycle 2; `inst`=32'h00500093/`inst_pc`=4 at cycle 5 (cycle 3 with `FETCH_WORD_REUSE_EN`).
- **Backpressure:** `inst_ready`=0 for 5 cycles. Required: `inst_valid` and `inst` held constant, pc unchanged, `imem_req`=0.
- **Stale response:** redirect to 0x100 in the cycle a request to 0x8 is accepted. Required: the 0x8 response is discarded; the next delivered `inst_pc`=0x100.
- **Misaligned redirect:** redirect to 0x102. Required: no `imem_req` for 0x102; `inst_fault`=1, `fault_misaligned`=1, `inst_pc`=0x102. After consumption, HALT with `imem_req`=0 until the next redirect.
- **Access error:** `imem_err`=1 with `imem_valid`. Required: `inst_fault`=1, `fault_misaligned`=0, then HALT.
- **Data contention:** data access occupying the controller when `imem_req` rises. Required: `imem_req` stays high, and the response arrives one cycle later than normal with the correct instruction.
